// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter feeding a one-entry registered output stage.
// The winner index drives a 4:1 mux built from two levels of 2:1 mux stages.
module rr_mux_arbiter_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);

    logic [1:0]       ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [1:0]       out_src_reg;

    logic [1:0]       winner;
    logic             free;
    logic             load;
    logic [WIDTH-1:0] data_arr [4];
    logic [WIDTH-1:0] stage1 [2];
    logic [WIDTH-1:0] mux_out;

    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;

    // Walk the rotated order backwards so the nearest requester after ptr wins;
    // offset 4 wraps onto ptr itself, giving it the lowest priority.
    always_comb begin
        logic [1:0] idx;
        idx    = '0;
        winner = ptr_reg;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr_reg + 2'(k);
            if (in_valid[idx]) begin
                winner = idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mux_stage1
            assign stage1[gi] = winner[0] ? data_arr[2*gi+1] : data_arr[2*gi];
        end
    endgenerate

    assign mux_out = winner[1] ? stage1[1] : stage1[0];

    assign free = !out_valid_reg || out_ready;
    assign load = !rst && free && (in_valid != 4'b0000);

    always_comb begin
        in_ready = 4'b0000;
        if (load) begin
            in_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= 2'd3;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= 2'd0;
        end else if (load) begin
            ptr_reg       <= winner;
            out_valid_reg <= 1'b1;
            out_data_reg  <= mux_out;
            out_src_reg   <= winner;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

endmodule
